alu_req_arbiter: RTL
====================

Name: alu_req_arbiter

Overview:
- Sequencer/arbiter that shares one 4-bit signed ALU between two requesters.
- Accepts operand/opcode requests over valid/ready and grants one at a time, round-robin or fixed priority.
- Drives the ALU operand/opcode inputs from registers, captures the 8-bit ALU result, and returns it on a valid/ready response channel tagged with the requester ID.
- Sits between the requesting units and the combinational ALU instance.

Parameters:
- EXEC_CYCLES, 1, cycles operands are held stable on the ALU before result capture; legal range 1..15, 0 illegal.
- PRIORITY_MODE, 0, 0 = round-robin; 1 = fixed priority, req0 always wins ties.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid_i  in  1  requester 0 has a request.
- req0_ready_o  out  1  requester 0 request accepted this cycle when valid high.
- req0_a_i  in  4  requester 0 operand A, signed.
- req0_b_i  in  4  requester 0 operand B, signed.
- req0_op_i  in  3  requester 0 opcode, ALU encoding 0..7.
- req1_valid_i, req1_ready_o, req1_a_i, req1_b_i, req1_op_i  same as requester 0.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  consumer takes response.
- rsp_data_o  out  8  captured ALU result.
- rsp_id_o  out  1  requester that owns the response.
- alu_a_o  out  4  to ALU A_i.
- alu_b_o  out  4  to ALU B_i.
- alu_op_o  out  3  to ALU opSel.
- alu_res_i  in  8  from ALU o_alu.
- busy_o  out  1  high when state is not IDLE.

Behaviour:
- FSM states are IDLE, EXEC and RESP.
- Reset (async, rst_n low) forces:
  - state = IDLE.
  - All outputs 0: alu_*_o, rsp_data_o, rsp_id_o, rsp_valid_o, busy_o.
  - Exec counter = 0.
  - last_grant = 1, so req0 wins first.
  - Reset mid-EXEC or mid-RESP discards the pending result, with no response.
- IDLE:
  - reqN_ready_o is combinational: high only for the selected requester, and only when its valid is high.
  - Selection, round-robin: if one valid, grant it; if both valid, grant the one that is not last_grant.
  - Selection, PRIORITY_MODE=1: req0 wins whenever req0_valid_i is high.
  - On valid&ready: latch a/b/op into the ALU drive registers, record grant id, update last_grant, load counter = EXEC_CYCLES-1, go to EXEC.
  - With no valid: stay in IDLE; ALU drive registers hold their previous values.
- EXEC:
  - Both ready_o are low.
  - alu_*_o stay stable from the registers.
  - When counter = 0: capture alu_res_i into rsp_data_o and the id into rsp_id_o, then go to RESP. Otherwise decrement the counter.
- RESP:
  - rsp_valid_o = 1; rsp_data_o and rsp_id_o are held stable until rsp_ready_i is high.
  - Handshake at a clock edge with rsp_valid_o&rsp_ready_i: go to IDLE and clear rsp_valid_o.
  - A new request cannot be accepted in the same cycle as the response handshake.
- Latency:
  - Acceptance in cycle c0.
  - EXEC occupies c1..cE, where E = EXEC_CYCLES.
  - rsp_valid_o is high from cycle c(E+1).
  - Minimum request spacing is E+2 cycles.
- Requests are not buffered; requesters must hold valid and payload stable until ready.
- The result is not modified; the block passes the ALU's sign-extension and wrap semantics through unchanged.

Optional Feature:
- Macro: ALU_OVF_FLAG_EN.
- Defined: adds output port rsp_ovf_o (1 bit), captured together with rsp_data_o, reset 0, computed from the latched operands and alu_res_i[3:0]:
  - op 4 (add): A and B have the same sign and the result sign differs.
  - op 5 (sub): A and B have different signs and the result sign differs from A.
  - op 6 (negate): A = -8.
  - All other ops: 0.
- Undefined: port rsp_ovf_o and its logic are absent; all other behaviour is identical.

Test Plan:
- Default params; req0 a=3, b=4, op=4 -> rsp_valid_o high 2 cycles after acceptance; rsp_data_o=0x07, rsp_id_o=0, busy_o high through RESP.
- Both requesters valid in the same cycle after reset: req0 a=-2, b=3, op=7; req1 a=5, b=-3, op=5 -> first response id=0, data=0xFA; second response id=1, data=0xF8 (rsp_ovf_o=1 when ALU_OVF_FLAG_EN is defined).
- rsp_ready_i held low 5 cycles during RESP -> rsp_valid_o, rsp_data_o and rsp_id_o stable; both ready_o low; req1 waiting with valid is not accepted until after the handshake.
- rst_n pulsed low during EXEC with EXEC_CYCLES=3 -> all outputs 0 immediately; no response appears; next request goes to req0 if both are valid.
- req0 a=-8, op=6 -> data=0xF8 (ovf=1 when enabled); req1 b=5, op=2 -> data=0x0A (ovf=0).
- PRIORITY_MODE=1 with both valid continuously for 4 transactions -> all four grants to req0; req1 is granted only after req0_valid_i drops.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Two-requester arbiter/sequencer sharing one combinational 4-bit signed ALU.
// Optional response overflow flag (port rsp_ovf_o) is built when ALU_OVF_FLAG_EN is defined.
module alu_req_arbiter #(
    parameter int EXEC_CYCLES   = 1,
    parameter int PRIORITY_MODE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid_i,
    output logic       req0_ready_o,
    input  logic [3:0] req0_a_i,
    input  logic [3:0] req0_b_i,
    input  logic [2:0] req0_op_i,
    input  logic       req1_valid_i,
    output logic       req1_ready_o,
    input  logic [3:0] req1_a_i,
    input  logic [3:0] req1_b_i,
    input  logic [2:0] req1_op_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [7:0] rsp_data_o,
    output logic       rsp_id_o,
`ifdef ALU_OVF_FLAG_EN
    output logic       rsp_ovf_o,
`endif
    output logic [3:0] alu_a_o,
    output logic [3:0] alu_b_o,
    output logic [2:0] alu_op_o,
    input  logic [7:0] alu_res_i,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LP_CNT_LOAD = 4'(EXEC_CYCLES - 1);

    generate
        if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
            $error("alu_req_arbiter: EXEC_CYCLES must be in 1..15");
        end
    endgenerate

    // Handshakes: a request transfers on a rising edge where reqN_valid_i && reqN_ready_o;
    // a response transfers on a rising edge where rsp_valid_o && rsp_ready_i.
    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_last_grant;
    logic       r_gnt_id;
    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic [2:0] r_alu_op;
    logic [7:0] r_rsp_data;
    logic       r_rsp_id;
    logic       r_rsp_valid;
    logic       r_busy;

    logic       w_idle;
    logic       w_pick1;
    logic       w_gnt0;
    logic       w_gnt1;

    assign w_idle  = (r_state == S_IDLE);
    // On a tie, round-robin hands the grant to whoever did not get it last time.
    assign w_pick1 = req1_valid_i &&
                     (!req0_valid_i || ((PRIORITY_MODE == 0) && !r_last_grant));
    assign w_gnt0  = w_idle && req0_valid_i && !w_pick1;
    assign w_gnt1  = w_idle && w_pick1;

    assign req0_ready_o = w_gnt0;
    assign req1_ready_o = w_gnt1;

`ifdef ALU_OVF_FLAG_EN
    logic w_ovf;
    logic r_ovf;

    // Signed overflow judged from the latched operands and the 4-bit result sign.
    always_comb begin
        w_ovf = 1'b0;
        case (r_alu_op)
            3'd4:    w_ovf = (r_alu_a[3] == r_alu_b[3]) && (alu_res_i[3] != r_alu_a[3]);
            3'd5:    w_ovf = (r_alu_a[3] != r_alu_b[3]) && (alu_res_i[3] != r_alu_a[3]);
            3'd6:    w_ovf = (r_alu_a == 4'b1000);
            default: w_ovf = 1'b0;
        endcase
    end

    assign rsp_ovf_o = r_ovf;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_last_grant <= 1'b1;
            r_gnt_id     <= 1'b0;
            r_alu_a      <= 4'd0;
            r_alu_b      <= 4'd0;
            r_alu_op     <= 3'd0;
            r_rsp_data   <= 8'd0;
            r_rsp_id     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_busy       <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
            r_ovf        <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_alu_a      <= w_gnt1 ? req1_a_i  : req0_a_i;
                        r_alu_b      <= w_gnt1 ? req1_b_i  : req0_b_i;
                        r_alu_op     <= w_gnt1 ? req1_op_i : req0_op_i;
                        r_gnt_id     <= w_gnt1;
                        r_last_grant <= w_gnt1;
                        r_cnt        <= LP_CNT_LOAD;
                        r_busy       <= 1'b1;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_data  <= alu_res_i;
                        r_rsp_id    <= r_gnt_id;
`ifdef ALU_OVF_FLAG_EN
                        r_ovf       <= w_ovf;
`endif
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_a_o     = r_alu_a;
    assign alu_b_o     = r_alu_b;
    assign alu_op_o    = r_alu_op;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_id_o    = r_rsp_id;
    assign busy_o      = r_busy;

endmodule
